// File: rtl/hazard_stall.sv
// D-stage stall controller for the 5-stage MIPS pipeline: tracks E/M/W destinations
// and result timing, and holds the mult/div busy counter that gates HI/LO users.
module hazard_stall #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  A3_D,
  input  logic        RWE_D,
  input  logic [1:0]  Tnew_D,
  input  logic        md_start_D,
  input  logic        md_div_D,
  input  logic        md_use_D,
  output logic        stall,
  output logic [4:0]  A3_E,
  output logic [4:0]  A3_M,
  output logic [4:0]  A3_W,
  output logic        RWE_E,
  output logic        RWE_M,
  output logic        RWE_W,
  output logic [1:0]  Tnew_E,
  output logic [1:0]  Tnew_M,
  output logic        md_busy
);

  logic [4:0]       a3E_q, a3E_d, a3M_q, a3M_d, a3W_q, a3W_d;
  logic             rweE_q, rweE_d, rweM_q, rweM_d, rweW_q, rweW_d;
  logic [1:0]       tnewE_q, tnewE_d, tnewM_q, tnewM_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       stallRsE, stallRsM, stallRtE, stallRtM, stallMd;
  logic       unusedIr;

  assign rsD      = IR_D[25:21];
  assign rtD      = IR_D[20:16];
  assign unusedIr = ^{IR_D[31:26], IR_D[15:0]};

  // A producer only blocks D when forwarding cannot deliver before the operand is used;
  // $0 is never a real dependency.
  assign stallRsE = (Tuse_rs_D < tnewE_q) && (rsD == a3E_q) && (a3E_q != 5'd0) && rweE_q;
  assign stallRsM = (Tuse_rs_D < tnewM_q) && (rsD == a3M_q) && (a3M_q != 5'd0) && rweM_q;
  assign stallRtE = (Tuse_rt_D < tnewE_q) && (rtD == a3E_q) && (a3E_q != 5'd0) && rweE_q;
  assign stallRtM = (Tuse_rt_D < tnewM_q) && (rtD == a3M_q) && (a3M_q != 5'd0) && rweM_q;

  assign md_busy = (cnt_q != '0);
  assign stallMd = (md_start_D | md_use_D) && md_busy;

  assign stall = stallRsE | stallRsM | stallRtE | stallRtM | stallMd;

  always_comb begin
    a3E_d   = A3_D;
    rweE_d  = RWE_D;
    tnewE_d = Tnew_D;
    if (stall) begin
      a3E_d   = 5'd0;
      rweE_d  = 1'b0;
      tnewE_d = 2'd0;
    end

    a3M_d   = a3E_q;
    rweM_d  = rweE_q;
    tnewM_d = (tnewE_q == 2'd0) ? 2'd0 : tnewE_q - 2'd1;

    a3W_d   = a3M_q;
    rweW_d  = rweM_q;

    // A start that is itself stalled never loads, so load-over-decrement is safe.
    cnt_d = cnt_q;
    if (md_start_D && !stall) begin
      cnt_d = md_div_D ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a3E_q   <= 5'd0;
      rweE_q  <= 1'b0;
      tnewE_q <= 2'd0;
      a3M_q   <= 5'd0;
      rweM_q  <= 1'b0;
      tnewM_q <= 2'd0;
      a3W_q   <= 5'd0;
      rweW_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a3E_q   <= a3E_d;
      rweE_q  <= rweE_d;
      tnewE_q <= tnewE_d;
      a3M_q   <= a3M_d;
      rweM_q  <= rweM_d;
      tnewM_q <= tnewM_d;
      a3W_q   <= a3W_d;
      rweW_q  <= rweW_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A3_E   = a3E_q;
  assign A3_M   = a3M_q;
  assign A3_W   = a3W_q;
  assign RWE_E  = rweE_q;
  assign RWE_M  = rweM_q;
  assign RWE_W  = rweW_q;
  assign Tnew_E = tnewE_q;
  assign Tnew_M = tnewM_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Scoreboarded bench for hazard_stall: a timeline model of in-flight producers and the
// mult/div busy window predicts every cycle's outputs, and a monitor compares them.
module tb_hazard_stall;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] IR_D;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic [4:0]  A3_D;
  logic        RWE_D, md_start_D, md_div_D, md_use_D;
  logic        stall, RWE_E, RWE_M, RWE_W, md_busy;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic [1:0]  Tnew_E, Tnew_M;

  always #5 clk = ~clk;

  hazard_stall #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .IR_D(IR_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .A3_D(A3_D), .RWE_D(RWE_D), .Tnew_D(Tnew_D), .md_start_D(md_start_D), .md_div_D(md_div_D),
    .md_use_D(md_use_D), .stall(stall), .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .RWE_E(RWE_E), .RWE_M(RWE_M), .RWE_W(RWE_W), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .md_busy(md_busy)
  );

  // Each in-flight instruction remembers the absolute cycle its result becomes ready.
  typedef struct {logic [4:0] a3; logic we; int ready;} rec_t;
  typedef struct {
    logic stall; logic [4:0] a3E, a3M, a3W; logic rweE, rweM, rweW;
    logic [1:0] tnewE, tnewM; logic busy;
  } exp_t;

  exp_t expQ[$];
  rec_t pipe[3];
  int   cyc = 0;
  int   mdBusyUntil = -1;
  int   total = 0;
  int   bad = 0;
  logic lastStall;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    total++;
    if (actual !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h (t=%0t)", name, actual, want, $time);
    end
  endtask

  function automatic int remaining(rec_t r);
    return (r.ready > cyc) ? r.ready - cyc : 0;
  endfunction

  function automatic logic hazard(logic [4:0] src, logic [1:0] tuse);
    for (int s = 0; s < 2; s++)
      if (pipe[s].we && pipe[s].a3 != 5'd0 && pipe[s].a3 == src && int'(tuse) < remaining(pipe[s]))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mkIr(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0000};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) pipe[i] = '{5'd0, 1'b0, 0};
    mdBusyUntil = -1;
  endtask

  task automatic driveNop();
    IR_D = 32'd0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3; A3_D = 5'd0; RWE_D = 1'b0;
    Tnew_D = 2'd0; md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic [1:0] tuseRs, input logic [1:0] tuseRt,
                               input logic [4:0] a3, input logic we, input logic [1:0] tnew,
                               input logic mdStart, input logic mdDiv, input logic mdUse);
    exp_t e;
    rec_t nr;
    logic busy, st;
    logic [4:0] rs, rt;
    @(posedge clk);
    #1;
    IR_D = ir; Tuse_rs_D = tuseRs; Tuse_rt_D = tuseRt; A3_D = a3; RWE_D = we; Tnew_D = tnew;
    md_start_D = mdStart; md_div_D = mdDiv; md_use_D = mdUse;
    rs = ir[25:21];
    rt = ir[20:16];
    busy = (cyc <= mdBusyUntil);
    st = hazard(rs, tuseRs) || hazard(rt, tuseRt) || ((mdStart || mdUse) && busy);
    e.stall = st;
    e.a3E = pipe[0].a3; e.a3M = pipe[1].a3; e.a3W = pipe[2].a3;
    e.rweE = pipe[0].we; e.rweM = pipe[1].we; e.rweW = pipe[2].we;
    e.tnewE = 2'(remaining(pipe[0]));
    e.tnewM = 2'(remaining(pipe[1]));
    e.busy = busy;
    expQ.push_back(e);
    if (st) nr = '{5'd0, 1'b0, 0};
    else    nr = '{a3, we, cyc + 1 + int'(tnew)};
    if (mdStart && !st) mdBusyUntil = cyc + (mdDiv ? DIV_N : MULT_N);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nr;
    cyc++;
    #1 lastStall = stall;
  endtask

  task automatic nop();
    applyStimulus(32'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Keeps an instruction in D until the DUT lets it through, counting stalled cycles.
  task automatic issue(input logic [31:0] ir, input logic [1:0] tuseRs, input logic [1:0] tuseRt,
                       input logic [4:0] a3, input logic we, input logic [1:0] tnew,
                       input logic mdStart, input logic mdDiv, input logic mdUse, output int stalls);
    logic done;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      applyStimulus(ir, tuseRs, tuseRt, a3, we, tnew, mdStart, mdDiv, mdUse);
      if (lastStall) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL issueBound got=stuck want=issued (t=%0t)", $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
    checkOutput({tag, "_busy"}, 32'(md_busy), 32'd0);
    checkOutput({tag, "_A3E"}, 32'(A3_E), 32'd0);
    checkOutput({tag, "_A3M"}, 32'(A3_M), 32'd0);
    checkOutput({tag, "_A3W"}, 32'(A3_W), 32'd0);
    checkOutput({tag, "_RWEE"}, 32'(RWE_E), 32'd0);
    checkOutput({tag, "_RWEM"}, 32'(RWE_M), 32'd0);
    checkOutput({tag, "_RWEW"}, 32'(RWE_W), 32'd0);
    checkOutput({tag, "_TnewE"}, 32'(Tnew_E), 32'd0);
    checkOutput({tag, "_TnewM"}, 32'(Tnew_M), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("stall", 32'(stall), 32'(e.stall));
      checkOutput("A3_E", 32'(A3_E), 32'(e.a3E));
      checkOutput("A3_M", 32'(A3_M), 32'(e.a3M));
      checkOutput("A3_W", 32'(A3_W), 32'(e.a3W));
      checkOutput("RWE_E", 32'(RWE_E), 32'(e.rweE));
      checkOutput("RWE_M", 32'(RWE_M), 32'(e.rweM));
      checkOutput("RWE_W", 32'(RWE_W), 32'(e.rweW));
      checkOutput("Tnew_E", 32'(Tnew_E), 32'(e.tnewE));
      checkOutput("Tnew_M", 32'(Tnew_M), 32'(e.tnewM));
      checkOutput("md_busy", 32'(md_busy), 32'(e.busy));
    end
  end

  initial begin
    int n;
    logic [4:0] rs, rt;
    logic start, use_;
    reset_n = 1'b0;
    driveNop();
    modelReset();
    #2 checkAllZero("rst");
    @(negedge clk);
    #2 reset_n = 1'b1;

    // lw $1 then add $2,$1,$3
    issue(mkIr(5'd0, 5'd1), 2'd1, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, n);
    issue(mkIr(5'd1, 5'd3), 2'd1, 2'd1, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, n);
    checkOutput("lwAddStalls", 32'(n), 32'd1);
    repeat (3) nop();

    // lw $1 then beq $1,$0
    issue(mkIr(5'd0, 5'd1), 2'd1, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, n);
    issue(mkIr(5'd1, 5'd0), 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n);
    checkOutput("lwBeqStalls", 32'(n), 32'd2);
    repeat (3) nop();

    // addu $0 then beq $0,$0
    issue(mkIr(5'd4, 5'd5), 2'd1, 2'd1, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, n);
    issue(mkIr(5'd0, 5'd0), 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, n);
    checkOutput("zeroRegStalls", 32'(n), 32'd0);
    repeat (3) nop();

    // mult then mflo
    issue(32'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, n);
    issue(32'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, n);
    checkOutput("multMfloStalls", 32'(n), 32'(MULT_N));
    repeat (3) nop();

    // div then div
    issue(32'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, n);
    issue(32'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, n);
    checkOutput("divDivStalls", 32'(n), 32'(DIV_N));
    repeat (12) nop();

    // reset three cycles into a div
    issue(32'd0, 2'd3, 2'd3, 5'd7, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, n);
    nop();
    nop();
    @(negedge clk);
    #1;
    checkOutput("busyBeforeReset", 32'(md_busy), 32'd1);
    md_start_D = 1'b1;
    md_use_D = 1'b1;
    reset_n = 1'b0;
    #1 checkAllZero("midRst");
    driveNop();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      start = ($urandom_range(0, 9) == 0);
      use_ = !start && ($urandom_range(0, 7) == 0);
      applyStimulus({6'($urandom), rs, rt, 16'($urandom)},
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom_range(0, 2)),
                    start, 1'($urandom), use_);
    end

    @(negedge clk);
    #1 checkOutput("queueDrain", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
